i2c_target: RTL

I2C target (slave) responder for the I2C IP: the other end of the command-driven I2C master, attached to the same open-drain `scl_io`/`sda_io` bus. It detects START and STOP conditions, matches a fixed 7-bit address, and acknowledges. It receives write bytes for the user logic and returns user-supplied bytes on reads. It never drives SCL (no clock stretching) and only ever pulls SDA low or releases it.

---
 rtl/i2c_target.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target responder: START/STOP detection, fixed 7-bit address match,
// write-data reception with optional ACK, and read-data transmission.
// SCL is only sampled; SDA is only pulled low or released.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk_i,
  input  logic       rst_i,
  inout  logic       scl_io,
  inout  logic       sda_io,
  input  logic       ack_en_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       nack_o,
  output logic       busy_o,
  output logic       rw_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_WR_NACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  state_t     state_q, state_d;
  // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  // Marks the second half of a two-edge step (ACK drive/release, ACK sample/resume)
  logic       phase_q, phase_d;
  logic       sda_drv_q, sda_drv_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       nack_q, nack_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_pipe_q[1];
  assign sda_s     = sda_pipe_q[1];
  assign scl_rise  = scl_pipe_q[1] & ~scl_pipe_q[2];
  assign scl_fall  = ~scl_pipe_q[1] & scl_pipe_q[2];
  assign start_det = scl_s & ~sda_pipe_q[1] & sda_pipe_q[2];
  assign stop_det  = scl_s & sda_pipe_q[1] & ~sda_pipe_q[2];

  assign sda_io     = sda_drv_q ? 1'b0 : 1'bz;
  assign tx_req_o   = tx_req_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign nack_o     = nack_q;
  assign busy_o     = busy_q;
  assign rw_o       = rw_q;

  // Synchronizer shift for both bus lines
  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl_io};
    sda_pipe_d = {sda_pipe_q[1:0], sda_io};
  end

  // Protocol FSM: bus conditions first, then per-state bit processing
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    sda_drv_d  = sda_drv_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    nack_d     = 1'b0;
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_drv_d = 1'b0;
      busy_d    = 1'b0;
      start_d   = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      sda_drv_d = 1'b0;
      busy_d    = 1'b0;
      stop_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q == ADDR) begin
              state_d = ST_ADDR_ACK;
              rw_d    = sda_s;
              phase_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_drv_d = 1'b1;
            busy_d    = 1'b1;
            phase_d   = 1'b1;
          end else begin
            sda_drv_d = 1'b0;
            phase_d   = 1'b0;
            if (rw_q) begin
              state_d  = ST_RD_DATA;
              tx_req_d = 1'b1;
            end else begin
              state_d  = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            if (ack_en_i) begin
              rx_data_d  = {shift_q, sda_s};
              rx_valid_d = 1'b1;
              state_d    = ST_WR_ACK;
            end else begin
              state_d    = ST_WR_NACK;
            end
          end
        end
        ST_WR_ACK: if (scl_fall) begin
          sda_drv_d = ~phase_q;
          phase_d   = ~phase_q;
          if (phase_q) state_d = ST_WR_DATA;
        end
        ST_WR_NACK: if (scl_fall) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        ST_RD_DATA: begin
          // Load happens in the cycle tx_req_o is high; an SCL fall cannot coincide
          if (tx_req_q) begin
            shift_d   = tx_data_i[6:0];
            sda_drv_d = ~tx_data_i[7];
            bit_cnt_d = '0;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_drv_d = 1'b0;
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = ST_RD_ACK;
            end else begin
              sda_drv_d = ~shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (!phase_q && scl_rise) begin
            if (sda_s) begin
              nack_d    = 1'b1;
              busy_d    = 1'b0;
              sda_drv_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              phase_d   = 1'b1;
            end
          end else if (phase_q && scl_fall) begin
            phase_d  = 1'b0;
            tx_req_d = 1'b1;
            state_d  = ST_RD_DATA;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      phase_q    <= 1'b0;
      sda_drv_q  <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      sda_drv_q  <= sda_drv_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
    end
  end

endmodule
